// File: rtl/seg_bank_viewer_if.sv
// Bus bundle for seg_bank_viewer: raw buttons and bank buses in, displays out.
// master drives btn_r/btn_m/bank_r/bank_m; slave drives idx_seg/val_seg/led/busy.
interface seg_bank_viewer_if #(
    parameter int N_ENTRIES  = 32,
    parameter int DATA_W     = 12,
    parameter int N_DIGITS   = 4,
    parameter int IDX_DIGITS = 2
);
    logic                        btn_r;
    logic                        btn_m;
    logic [N_ENTRIES*DATA_W-1:0] bank_r;
    logic [N_ENTRIES*DATA_W-1:0] bank_m;
    logic [IDX_DIGITS*7-1:0]     idx_seg;
    logic [N_DIGITS*7-1:0]       val_seg;
    logic [1:0]                  led;
    logic                        busy;

    modport master (
        output btn_r, btn_m, bank_r, bank_m,
        input  idx_seg, val_seg, led, busy
    );

    modport slave (
        input  btn_r, btn_m, bank_r, bank_m,
        output idx_seg, val_seg, led, busy
    );
endinterface

// File: rtl/seg_bank_viewer.sv
// Two-bank viewer: debounced buttons pick bank/index, value shown via shift-add-3 BCD.
// Ports: clk, reset (async, active-high), bus (slave: buttons, banks, segments, led, busy).
module seg_bank_viewer #(
    parameter int N_ENTRIES  = 32,
    parameter int DATA_W     = 12,
    parameter int N_DIGITS   = 4,
    parameter int IDX_DIGITS = 2,
    parameter int DEB_CYCLES = 16,
    parameter int AUTO_REFR  = 0
) (
    input logic               clk,
    input logic               reset,
    seg_bank_viewer_if.slave  bus
);
    localparam int IW    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    // ceil(DATA_W*0.302 + 1) BCD digits
    localparam int ACC_D = (DATA_W * 302 + 1999) / 1000;
    localparam int AW    = 4 * ACC_D;
    localparam int PW    = 4 * ((ACC_D > N_DIGITS) ? ACC_D : N_DIGITS);
    localparam int CW    = $clog2(DATA_W + 1);
    localparam int DCW   = $clog2(DEB_CYCLES + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_UPDATE} state_t;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // bit 0 = R, bit 1 = M
    logic [1:0]     r_s1, r_s2, r_deb, r_deb_d;
    logic [DCW-1:0] r_dcnt [2];
    logic [1:0]     w_press;

    state_t                  r_state, w_next;
    logic                    r_start;
    logic                    r_bank;
    logic [IW-1:0]           r_idx;
    logic [IDX_DIGITS*4-1:0] r_idx_bcd, w_idx_inc;
    logic                    r_idx_on;
    logic [DATA_W-1:0]       r_shift;
    logic [AW-1:0]           r_acc, w_acc_adj;
    logic [CW-1:0]           r_cnt;
    logic [N_DIGITS*7-1:0]   r_val_seg, w_val_seg;
    logic [IDX_DIGITS*7-1:0] w_idx_seg;
    logic [PW-1:0]           w_acc_pad;
    logic                    w_ovf, w_carry;
    logic                    w_acc_r, w_acc_m, w_step, w_switch, w_wrap;
    logic [N_ENTRIES*DATA_W-1:0] w_bank_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
        end else begin
            r_s1    <= {bus.btn_m, bus.btn_r};
            r_s2    <= r_s1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] != r_deb[i]) begin
                    if (r_dcnt[i] == DCW'(DEB_CYCLES - 1)) begin
                        r_deb[i]  <= r_s2[i];
                        r_dcnt[i] <= '0;
                    end else begin
                        r_dcnt[i] <= r_dcnt[i] + DCW'(1);
                    end
                end else begin
                    r_dcnt[i] <= '0;
                end
            end
        end
    end

    assign w_press  = r_deb & ~r_deb_d;
    // R wins a same-cycle tie; presses outside IDLE are dropped
    assign w_acc_r  = (r_state == S_IDLE) && w_press[0];
    assign w_acc_m  = (r_state == S_IDLE) && w_press[1] && !w_press[0];
    assign w_step   = (w_acc_r && !r_bank) || (w_acc_m && r_bank);
    assign w_switch = (w_acc_r && r_bank) || (w_acc_m && !r_bank);
    assign w_wrap   = (r_idx == IW'(N_ENTRIES - 1));
    assign w_bank_sel = r_bank ? bus.bank_m : bus.bank_r;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:
                if (w_press != 2'b00 || r_start || AUTO_REFR != 0)
                    w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT:
                if (r_cnt == CW'(DATA_W - 1))
                    w_next = S_UPDATE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_idx_inc = r_idx_bcd;
        w_carry   = 1'b1;
        for (int d = 0; d < IDX_DIGITS; d++) begin
            if (w_carry) begin
                if (r_idx_bcd[4*d +: 4] == 4'd9) begin
                    w_idx_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_idx_inc[4*d +: 4] = r_idx_bcd[4*d +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_acc_adj = r_acc;
        for (int d = 0; d < ACC_D; d++)
            if (r_acc[4*d +: 4] >= 4'd5)
                w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end

    // Padding lets N_DIGITS exceed the accumulator without out-of-range selects
    assign w_acc_pad = PW'(r_acc);
    assign w_ovf     = (w_acc_pad >> (4 * N_DIGITS)) != '0;

    always_comb begin
        w_val_seg = '1;
        for (int d = 0; d < N_DIGITS; d++)
            w_val_seg[7*d +: 7] = w_ovf ? SEG_DASH : f_seg(w_acc_pad[4*d +: 4]);
        w_idx_seg = '1;
        for (int d = 0; d < IDX_DIGITS; d++)
            w_idx_seg[7*d +: 7] = f_seg(r_idx_bcd[4*d +: 4]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start   <= 1'b1;
            r_bank    <= 1'b0;
            r_idx     <= '0;
            r_idx_bcd <= '0;
            r_idx_on  <= 1'b0;
            r_shift   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_val_seg <= '1;
        end else begin
            if (w_step) begin
                r_idx     <= w_wrap ? '0 : r_idx + IW'(1);
                r_idx_bcd <= w_wrap ? '0 : w_idx_inc;
            end
            if (w_switch) r_bank <= ~r_bank;
            case (r_state)
                S_LOAD: begin
                    r_shift  <= w_bank_sel[r_idx*DATA_W +: DATA_W];
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_start  <= 1'b0;
                    r_idx_on <= 1'b1;
                end
                S_SHIFT: begin
                    r_acc   <= {w_acc_adj[AW-2:0], r_shift[DATA_W-1]};
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                S_UPDATE: r_val_seg <= w_val_seg;
                default: ;
            endcase
        end
    end

    // New value appears during UPDATE itself, then is held by r_val_seg
    assign bus.val_seg = (r_state == S_UPDATE) ? w_val_seg : r_val_seg;
    assign bus.idx_seg = r_idx_on ? w_idx_seg : '1;
    assign bus.led     = r_bank ? 2'b10 : 2'b01;
    assign bus.busy    = (r_state == S_LOAD) || (r_state == S_SHIFT);
endmodule

// File: tb/tb_seg_bank_viewer.sv
// Directed/randomized bench for seg_bank_viewer with a decimal reference model.
// Two DUTs: defaults (4 digits, event-driven) and 3 digits with auto refresh.
module tb_seg_bank_viewer;
    localparam int NE  = 32;
    localparam int DW  = 12;
    localparam int DEB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_r = 1'b0;
    logic btn_m = 1'b0;
    logic [NE*DW-1:0] bank_r, bank_m;
    logic [DW-1:0] mr [NE];
    logic [DW-1:0] mm [NE];

    int n_tests = 0;
    int n_fail  = 0;
    int m_idx, m_bank, m_val, k;

    always #5 clk = ~clk;

    always_comb begin
        bank_r = '0;
        bank_m = '0;
        for (int i = 0; i < NE; i++) begin
            bank_r[i*DW +: DW] = mr[i];
            bank_m[i*DW +: DW] = mm[i];
        end
    end

    seg_bank_viewer_if #(.N_ENTRIES(NE), .DATA_W(DW), .N_DIGITS(4), .IDX_DIGITS(2)) bus0 ();
    seg_bank_viewer_if #(.N_ENTRIES(NE), .DATA_W(DW), .N_DIGITS(3), .IDX_DIGITS(2)) bus1 ();

    assign bus0.btn_r  = btn_r;
    assign bus0.btn_m  = btn_m;
    assign bus0.bank_r = bank_r;
    assign bus0.bank_m = bank_m;
    assign bus1.btn_r  = 1'b0;
    assign bus1.btn_m  = 1'b0;
    assign bus1.bank_r = bank_r;
    assign bus1.bank_m = bank_m;

    seg_bank_viewer #(
        .N_ENTRIES(NE), .DATA_W(DW), .N_DIGITS(4), .IDX_DIGITS(2),
        .DEB_CYCLES(DEB), .AUTO_REFR(0)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    seg_bank_viewer #(
        .N_ENTRIES(NE), .DATA_W(DW), .N_DIGITS(3), .IDX_DIGITS(2),
        .DEB_CYCLES(DEB), .AUTO_REFR(1)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [31:0] vexp(input int v, input int nd);
        logic [31:0] r;
        int lim, p;
        r = '0;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[i*7 +: 7] = (v >= lim) ? 7'b0111111 : seg((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] iexp(input int idx);
        return {18'd0, seg((idx / 10) % 10), seg(idx % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_idx"}, 32'(bus0.idx_seg), iexp(m_idx));
        chk({tag, "_val"}, 32'(bus0.val_seg), vexp(m_val, 4));
        chk({tag, "_led"}, 32'(bus0.led), (m_bank != 0) ? 32'd2 : 32'd1);
        chk({tag, "_busy"}, 32'(bus0.busy), 32'd0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_press(input bit r, input bit m);
        if (r) begin
            if (m_bank == 0) m_idx = (m_idx + 1) % NE;
            else m_bank = 0;
        end else if (m) begin
            if (m_bank == 1) m_idx = (m_idx + 1) % NE;
            else m_bank = 1;
        end
        m_val = (m_bank != 0) ? int'(mm[m_idx]) : int'(mr[m_idx]);
    endtask

    task automatic press(input bit r, input bit m);
        btn_r = r;
        btn_m = m;
        cyc(DEB + 8);
        btn_r = 1'b0;
        btn_m = 1'b0;
        cyc(DEB + 8);
        model_press(r, m);
    endtask

    initial begin
        for (int i = 0; i < NE; i++) begin
            mr[i] = DW'($urandom % 4096);
            mm[i] = DW'($urandom % 4096);
        end
        mr[0] = 12'd1234;
        mr[3] = 12'd4095;
        reset = 1'b1;
        cyc(3);
        chk("rst_idx", 32'(bus0.idx_seg), 32'h3fff);
        chk("rst_val", 32'(bus0.val_seg), 32'h0fff_ffff);
        chk("rst_led", 32'(bus0.led), 32'd1);
        chk("rst_busy", 32'(bus0.busy), 32'd0);

        reset = 1'b0;
        m_idx = 0;
        m_bank = 0;
        m_val = 1234;
        cyc(1);
        chk("start_busy", 32'(bus0.busy), 32'd1);
        cyc(DW + 4);
        check_all("r0");
        chk("auto_1234", 32'(bus1.val_seg), vexp(1234, 3));

        for (int i = 1; i <= NE; i++) begin
            press(1'b1, 1'b0);
            check_all($sformatf("step%0d", i));
        end

        for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
        check_all("idx5");
        press(1'b0, 1'b1);
        check_all("to_m");
        press(1'b1, 1'b1);
        check_all("both");

        // M pulse lands while the R-triggered conversion is busy
        btn_r = 1'b1;
        cyc(3);
        btn_m = 1'b1;
        cyc(DEB + 8);
        btn_r = 1'b0;
        btn_m = 1'b0;
        cyc(DEB + 8);
        model_press(1'b1, 1'b0);
        check_all("busy_drop");

        repeat (5) begin
            btn_r = 1'b1;
            cyc(5);
            btn_r = 1'b0;
            cyc(3);
        end
        cyc(30);
        check_all("glitch");

        mr[0] = 12'd4095;
        cyc(2 * (DW + 3) + 4);
        chk("auto_4095", 32'(bus1.val_seg), vexp(4095, 3));
        mr[0] = DW'($urandom_range(0, 999));
        cyc(2 * (DW + 3) + 4);
        chk("auto_live", 32'(bus1.val_seg), vexp(int'(mr[0]), 3));
        check_all("no_auto");

        btn_r = 1'b1;
        for (k = 0; k < 100 && !bus0.busy; k++) cyc(1);
        chk("wait_busy", 32'(bus0.busy), 32'd1);
        cyc(4);
        reset = 1'b1;
        #1;
        chk("mid_idx", 32'(bus0.idx_seg), 32'h3fff);
        chk("mid_val", 32'(bus0.val_seg), 32'h0fff_ffff);
        chk("mid_led", 32'(bus0.led), 32'd1);
        chk("mid_busy", 32'(bus0.busy), 32'd0);
        btn_r = 1'b0;
        cyc(3);
        reset = 1'b0;
        m_idx = 0;
        m_bank = 0;
        m_val = int'(mr[0]);
        cyc(DW + 6);
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
